// File: rtl/recebe_ascii_bcd.sv
// Receive-side ASCII-to-BCD assembler: takes a tens then a units decimal character
// from the UART receiver, with a per-character timeout while waiting.
module recebe_ascii_bcd #(
  parameter int TIMEOUT_CICLOS = 50000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       recebe_bcd,
  input  logic       pronto_recepcao,
  input  logic [7:0] dado_recepcao,
  output logic [7:0] bcd,
  output logic       pronto,
  output logic       erro,
  output logic [2:0] db_estado
);

  localparam int CNT_W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CICLOS - 1);

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    ESPERA_DEZENA  = 3'd1,
    ESPERA_UNIDADE = 3'd2,
    FIM            = 3'd3,
    ERRO           = 3'd4
  } estado_t;

  estado_t          estado_q, estado_d;
  logic [3:0]       dezena_q, dezena_d;
  logic [7:0]       bcd_q, bcd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             digito_ok, espera, expirou;

  assign digito_ok = (dado_recepcao >= 8'h30) && (dado_recepcao <= 8'h39);
  assign espera    = (estado_q == ESPERA_DEZENA) || (estado_q == ESPERA_UNIDADE);
  assign expirou   = (cnt_q == CNT_MAX);

  // A strobe is tested before expiry so a character in the last wait cycle wins.
  always_comb begin
    estado_d = estado_q;
    dezena_d = dezena_q;
    bcd_d    = bcd_q;
    case (estado_q)
      IDLE:
        if (recebe_bcd) estado_d = ESPERA_DEZENA;
      ESPERA_DEZENA:
        if (pronto_recepcao) begin
          if (digito_ok) begin
            dezena_d = dado_recepcao[3:0];
            estado_d = ESPERA_UNIDADE;
          end else begin
            estado_d = ERRO;
          end
        end else if (expirou) begin
          estado_d = ERRO;
        end
      ESPERA_UNIDADE:
        if (pronto_recepcao) begin
          if (digito_ok) begin
            bcd_d    = {dezena_q, dado_recepcao[3:0]};
            estado_d = FIM;
          end else begin
            estado_d = ERRO;
          end
        end else if (expirou) begin
          estado_d = ERRO;
        end
      FIM, ERRO:
        estado_d = IDLE;
      default:
        estado_d = IDLE;
    endcase

    // Restart the count on every state change; only wait states advance it.
    cnt_d = cnt_q;
    if (estado_d != estado_q) cnt_d = '0;
    else if (espera)          cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= IDLE;
      dezena_q <= 4'h0;
      bcd_q    <= 8'h00;
      cnt_q    <= '0;
    end else begin
      estado_q <= estado_d;
      dezena_q <= dezena_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bcd       = bcd_q;
  assign pronto    = (estado_q == FIM);
  assign erro      = (estado_q == ERRO);
  assign db_estado = estado_q;

endmodule
